adder_rr_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one adder_8bit instance among NUM_REQ requesters. Each requester issues an (a, b, cin) operation with a valid/ready handshake. The block captures the winning request, drives the shared adder from registered operands, and returns sum/overflow/carry tagged with the requester ID on a single response channel with backpressure. It sits between the client blocks and the 8-bit adder datapath.

---
 rtl/adder_rr_arb.sv | 147 ++++++++++++++
 tb/tb_adder_rr_arb.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arb.sv
// adder_rr_arb: round-robin front end that shares one adder_8bit among NUM_REQ requesters.
// Optional overflow-response counter is compiled in when ADDER_RR_ARB_STATS_EN is defined.
module adder_8bit (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_cin,
   output logic [7:0] o_sum,
   output logic       o_ovf,
   output logic       o_carry
);
   logic [8:0] w_full;
   assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
   assign o_sum   = w_full[7:0];
   assign o_carry = w_full[8];
   assign o_ovf   = (i_a[7] == i_b[7]) && (w_full[7] != i_a[7]);
endmodule

module adder_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   output logic [NUM_REQ-1:0]   o_req_ready,
   input  logic [NUM_REQ*8-1:0] i_req_a,
   input  logic [NUM_REQ*8-1:0] i_req_b,
   input  logic [NUM_REQ-1:0]   i_req_cin,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [ID_W-1:0]      o_rsp_id,
   output logic [7:0]           o_rsp_sum,
   output logic                 o_rsp_ovf,
   output logic                 o_rsp_carry
`ifdef ADDER_RR_ARB_STATS_EN
   ,
   input  logic                 i_cnt_clr,
   output logic [7:0]           o_ovf_cnt
`endif
);
   localparam int NSLOT = 1 << ID_W;

   typedef enum logic {S_IDLE, S_RESP} state_t;
   state_t r_state, w_state_nxt;

   logic [ID_W-1:0]       r_ptr, r_id, w_win, w_ptr_nxt;
   logic [7:0]            r_a, r_b;
   logic                  r_cin;
   logic                  w_found, w_can_accept, w_take;
   logic [ID_W:0]         w_idx;

   // Pad request vectors to a full ID_W-indexed range so any pointer value is a legal index.
   logic [NSLOT-1:0]         w_vld;
   logic [NSLOT-1:0]         w_cin;
   logic [NSLOT-1:0][7:0]    w_a, w_b;
   assign w_vld = NSLOT'(i_req_valid);
   assign w_cin = NSLOT'(i_req_cin);
   assign w_a   = (NSLOT*8)'(i_req_a);
   assign w_b   = (NSLOT*8)'(i_req_b);

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_idx = {1'b0, r_ptr} + (ID_W+1)'(i);
         if (w_idx >= (ID_W+1)'(NUM_REQ)) w_idx = w_idx - (ID_W+1)'(NUM_REQ);
         if (!w_found && w_vld[w_idx[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[ID_W-1:0];
         end
      end
   end

   assign w_ptr_nxt = (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;

   always_comb begin
      w_state_nxt  = r_state;
      w_can_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_can_accept = 1'b1;
            if (w_found) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            w_can_accept = i_rsp_ready;
            if (i_rsp_ready && !w_found) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Reset gates the grant so nothing is offered while the block is held in reset.
   assign w_take = w_can_accept && w_found && i_rst_n;

   always_comb begin
      o_req_ready = '0;
      for (int k = 0; k < NUM_REQ; k++)
         o_req_ready[k] = w_take && (w_win == ID_W'(k));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
         r_id  <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_cin <= 1'b0;
      end else if (w_take) begin
         r_ptr <= w_ptr_nxt;
         r_id  <= w_win;
         r_a   <= w_a[w_win];
         r_b   <= w_b[w_win];
         r_cin <= w_cin[w_win];
      end
   end

   adder_8bit u_add (
      .i_a     (r_a),
      .i_b     (r_b),
      .i_cin   (r_cin),
      .o_sum   (o_rsp_sum),
      .o_ovf   (o_rsp_ovf),
      .o_carry (o_rsp_carry)
   );

   assign o_rsp_valid = (r_state == S_RESP);
   assign o_rsp_id    = r_id;

`ifdef ADDER_RR_ARB_STATS_EN
   logic [7:0] r_ovf_cnt;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_ovf_cnt <= '0;
      else if (i_cnt_clr)
         r_ovf_cnt <= '0;
      else if (o_rsp_valid && i_rsp_ready && o_rsp_ovf && (r_ovf_cnt != 8'hFF))
         r_ovf_cnt <= r_ovf_cnt + 8'd1;
   end
   assign o_ovf_cnt = r_ovf_cnt;
`endif
endmodule

// File: tb/tb_adder_rr_arb.sv
// Scoreboard bench for adder_rr_arb: a queue-based reference model predicts grants and responses.
module tb_adder_rr_arb;
   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*8-1:0]  req_a = '0;
   logic [N*8-1:0]  req_b = '0;
   logic [N-1:0]    req_cin = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [IW-1:0]   rsp_id;
   logic [7:0]      rsp_sum;
   logic            rsp_ovf, rsp_carry;
`ifdef ADDER_RR_ARB_STATS_EN
   logic            cnt_clr = 1'b0;
   logic [7:0]      ovf_cnt;
   int              m_cnt = 0;
`endif

   adder_rr_arb #(.NUM_REQ(N), .ID_W(IW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_a(req_a), .i_req_b(req_b), .i_req_cin(req_cin),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_id(rsp_id), .o_rsp_sum(rsp_sum), .o_rsp_ovf(rsp_ovf), .o_rsp_carry(rsp_carry)
`ifdef ADDER_RR_ARB_STATS_EN
      , .i_cnt_clr(cnt_clr), .o_ovf_cnt(ovf_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [7:0]    sum;
      logic          ovf;
      logic          carry;
   } rsp_t;

   int           n_cmp = 0, n_bad = 0;
   rsp_t         q[$];
   int           grant_log[$];
   int           m_ptr = 0;
   bit           m_busy = 0;
   logic [N-1:0] last_take = '0;
   logic [N-1:0] sticky = '0;
   bit           rnd = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic, signed overflow from the signed-range check.
   function automatic rsp_t ref_op(int id, int a, int b, int c);
      rsp_t r;
      int s, sa, sb, ss;
      s  = a + b + c;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      ss = sa + sb + c;
      r.id    = IW'(id);
      r.sum   = 8'(s % 256);
      r.carry = (s > 255);
      r.ovf   = (ss > 127) || (ss < -128);
      return r;
   endfunction

   always @(negedge rst_n) begin
      q.delete();
      m_busy    = 0;
      m_ptr     = 0;
      last_take = '0;
`ifdef ADDER_RR_ARB_STATS_EN
      m_cnt = 0;
`endif
   end

   // Model: predicts the grant for this cycle and queues the response it will produce.
   always begin : model
      bit           can;
      int           win, k;
      logic [N-1:0] exp_g;
      @(negedge clk); #1;
      if (rst_n) begin
         can = !m_busy || rsp_ready;
         win = -1;
         if (can)
            for (int i = 0; i < N; i++) begin
               k = (m_ptr + i) % N;
               if (win < 0 && req_valid[k]) win = k;
            end
         exp_g = '0;
         if (win >= 0) exp_g[win] = 1'b1;
         chk("grant", 32'(req_ready), 32'(exp_g));
         last_take = req_ready & req_valid;
         if (win >= 0) begin
            q.push_back(ref_op(win, int'(req_a[win*8 +: 8]), int'(req_b[win*8 +: 8]), int'(req_cin[win])));
            grant_log.push_back(win);
            m_ptr  = (win + 1) % N;
            m_busy = 1;
         end else if (rsp_ready) begin
            m_busy = 0;
         end
      end
   end

   // Monitor: compares the presented response against the queue head, pops on handshake.
   always begin : mon
      rsp_t e;
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_valid", 32'(rsp_valid), 32'd0);
         chk("rst_ready", 32'(req_ready), 32'd0);
         chk("rst_sum",   32'(rsp_sum),   32'd0);
         chk("rst_id",    32'(rsp_id),    32'd0);
      end else begin
         chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
`ifdef ADDER_RR_ARB_STATS_EN
         chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
`endif
         if (rsp_valid && q.size() != 0) begin
            e = q[0];
            chk("rsp_id",    32'(rsp_id),    32'(e.id));
            chk("rsp_sum",   32'(rsp_sum),   32'(e.sum));
            chk("rsp_ovf",   32'(rsp_ovf),   32'(e.ovf));
            chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
            if (rsp_ready) begin
               void'(q.pop_front());
`ifdef ADDER_RR_ARB_STATS_EN
               if (e.ovf && m_cnt < 255) m_cnt++;
`endif
            end
         end
      end
   end

   task automatic load(int k, logic [7:0] a, logic [7:0] b, logic c);
      req_valid[k]      = 1'b1;
      req_a[k*8 +: 8]   = a;
      req_b[k*8 +: 8]   = b;
      req_cin[k]        = c;
   endtask

   task automatic load_rnd(int k);
      load(k, 8'($urandom), 8'($urandom), 1'($urandom));
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk); #1;
         for (int k = 0; k < N; k++) begin
            if (last_take[k]) begin
               if (sticky[k] || (rnd && $urandom_range(1, 0) == 1)) load_rnd(k);
               else req_valid[k] = 1'b0;
            end else if (rnd) begin
               if (!req_valid[k] && $urandom_range(3, 0) == 0) load_rnd(k);
               else if (req_valid[k] && $urandom_range(15, 0) == 0) req_valid[k] = 1'b0;
            end
         end
         if (rnd) rsp_ready = ($urandom_range(3, 0) != 0);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      sticky    = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      // Reset, then idle with no requests
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step(3);
      chk("idle_valid", 32'(rsp_valid), 32'd0);

      // Single requester 1: 0x50+0x50
      rsp_ready = 1'b1;
      load(1, 8'h50, 8'h50, 1'b0);
      @(negedge clk);
      chk("t1_ready", 32'(req_ready), 32'b0010);
      step(1);
      @(negedge clk);
      chk("t1_id",  32'(rsp_id),  32'd1);
      chk("t1_sum", 32'(rsp_sum), 32'hA0);
      chk("t1_ovf", 32'(rsp_ovf), 32'd1);
      chk("t1_cy",  32'(rsp_carry), 32'd0);
      step(2);

      // Four simultaneous requesters, pointer at 0
      do_reset();
      rsp_ready = 1'b1;
      grant_log.delete();
      load(0, 8'h80, 8'h80, 1'b0);
      load(1, 8'h7F, 8'h01, 1'b0);
      load(2, 8'h55, 8'h2A, 1'b1);
      load(3, 8'hF8, 8'hF8, 1'b0);
      step(6);
      chk("rr4_count", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() == 4)
         for (int i = 0; i < 4; i++) chk("rr4_order", 32'(grant_log[i]), 32'(i));

      // Backpressure with requester 2 waiting
      do_reset();
      load(0, 8'h04, 8'hFC, 1'b0);
      step(1);
      load(2, 8'h11, 8'h22, 1'b0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_sum",   32'(rsp_sum),   32'h00);
         chk("bp_carry", 32'(rsp_carry), 32'd1);
         chk("bp_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_grant", 32'(req_ready), 32'b0100);
      step(3);

      // Fairness: requesters 0 and 3 continuously valid
      do_reset();
      rsp_ready = 1'b1;
      sticky    = 4'b1001;
      load_rnd(0);
      load_rnd(3);
      grant_log.delete();
      step(8);
      chk("fair_count", 32'(grant_log.size() >= 8), 32'd1);
      if (grant_log.size() >= 8)
         for (int i = 0; i < 8; i++) chk("fair_alt", 32'(grant_log[i]), (i % 2 == 1) ? 32'd3 : 32'd0);
      sticky = '0;
      step(3);

      // Reset mid-operation drops the response asynchronously
      do_reset();
      load(2, 8'h33, 8'h44, 1'b0);
      step(1);
      @(negedge clk);
      chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("async_drop", 32'(rsp_valid), 32'd0);
      load_rnd(3);
      load_rnd(1);
      grant_log.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      rsp_ready = 1'b1;
      step(3);
      chk("post_rst_first", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF, 32'd1);

      // Randomized traffic with random backpressure
      rnd = 1;
      step(2000);
      rnd = 0;
      rsp_ready = 1'b1;
      req_valid = '0;
      step(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
